gpio_controller: RTL and testbench
==================================

# gpio_controller

Parametrised memory-mapped GPIO block for the I/O window (0x0020-0x003F) of the memory controller, replacing the fixed 4-in/4-out switch/LED controller. Provides synchronised inputs, an output register with atomic set/clear/toggle, and per-bit rising/falling edge detection with sticky write-1-to-clear status and a level interrupt. All state updates on the falling edge of `clock`, so read data is stable for the CPU's next rising edge.

## Interface
- `NUM_IN`, 4: number of input pins; 1..DATA_WIDTH.
- `NUM_OUT`, 4: number of output pins; 1..DATA_WIDTH.
- `DATA_WIDTH`, 32: bus data width.
- `SYNC_STAGES`, 2: input synchroniser depth; >= 2.

- `clock` in 1: system clock; one clock domain only.
- `reset_n` in 1: reset, asynchronous, active-low.
- `chip_select` in 1: I/O window decode from the memory controller.
- `we` in 1: 1 = write, 0 = read.
- `address` in 5: word offset within the I/O window.
- `data_in` in DATA_WIDTH: write data.
- `data_out` out DATA_WIDTH: registered read data.
- `io_in` in NUM_IN: asynchronous external inputs (switches).
- `io_out` out NUM_OUT: registered outputs (LEDs).
- `irq` out 1: OR of all IRQ_STATUS bits.

## Operation
- Register map (word offsets); inputs/outputs are zero-extended on read:
  - 0x00 IN (RO): synchronised inputs.
  - 0x01 OUT (RW): output register; drives `io_out` directly.
  - 0x02 OUT_SET (WO): OUT |= data_in. Reads return 0.
  - 0x03 OUT_CLR (WO): OUT &= ~data_in. Reads return 0.
  - 0x04 OUT_TGL (WO): OUT ^= data_in. Reads return 0.
  - 0x05 RISE_EN (RW): per-input rising-edge enable.
  - 0x06 FALL_EN (RW): per-input falling-edge enable.
  - 0x07 IRQ_STATUS (RW1C): sticky edge flags.
  - 0x08-0x1F: reads return 0; writes are ignored.
- Write data bits above NUM_IN or NUM_OUT are ignored.
- Access: `chip_select && we` performs the write; `chip_select && !we` loads `data_out` with the register value. When `chip_select` is low, `data_out` is driven to 0. The block never tri-states.
- Synchroniser: `SYNC_STAGES` flops per input bit, then a `prev` flop holding the last synchronised value.
- Edge terms: rise = sync_last & ~prev & RISE_EN; fall = ~sync_last & prev & FALL_EN.
- Status update: IRQ_STATUS <= (IRQ_STATUS & ~clear_mask) | rise | fall.
- Simultaneous events: if a new edge and a W1C of the same bit occur on the same edge, set wins and the bit stays 1.
- A read of IRQ_STATUS returns the pre-update value and does not clear anything.
- Reset (async, `reset_n` low): `io_out`, `data_out`, `irq`, OUT, RISE_EN, FALL_EN, IRQ_STATUS, sync chain and `prev` all go to 0.
- Enables reset to 0, so spurious edges from the sync chain filling after reset never set status.
- Reset mid-operation: all state clears immediately, with no pending write or flag retained.

## Timing
- Register write: takes effect at the falling edge where `chip_select && we` is sampled. `io_out` changes at that edge.
- Read latency: `data_out` is valid after the falling edge that samples the read, i.e. one half-cycle, ready for the next rising edge.
- Input path: a change on `io_in` appears in IN after SYNC_STAGES falling edges.
- Status path: the matching status bit sets on the next falling edge (SYNC_STAGES+1 total). `irq` is combinational from IRQ_STATUS, so it asserts in the same half-cycle.
- Pulse width: input pulses shorter than one clock period may be missed. There is no pulse stretching.

## Structure
- Package `gpio_pkg`: register offset constants (GPIO_IN, GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_IRQ_STATUS).
- Sub-module `gpio_sync`: parametrised WIDTH x STAGES synchroniser with async active-low reset; instantiated once for all inputs.
- Top level holds the register file, edge logic, read mux and output register.

## Test plan
- Reset with `io_in`=4'hF, then release -> `io_out`=0, `data_out`=0, `irq`=0; read IN after 3 edges returns 32'h0000000F; IRQ_STATUS reads 0.
- Write OUT=0x5, SET 0x2, CLR 0x1, TGL 0xC -> `io_out` goes 0x5, 0x7, 0x6, 0xA, each at the write's falling edge.
- RISE_EN=0x1; drive `io_in[0]` 0->1 -> IRQ_STATUS=0x1 and `irq`=1 exactly SYNC_STAGES+1 falling edges later; W1C 0x1 -> `irq`=0.
- FALL_EN=0x2; time a falling edge on bit1 to coincide with a W1C of 0x2 -> status bit1 remains 1.
- Read offset 0x03 and 0x1A -> 0. Write 0xFFFFFFFF to 0x10 -> no register changes.
- Deselect `chip_select` -> `data_out`=0. Assert `reset_n` low mid-sequence with IRQ_STATUS=0x3 -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the memory-mapped GPIO block.
// Holds the register word offsets within the 32-word I/O window.
package gpio_pkg;

  localparam int unsigned GPIO_ADDR_WIDTH = 5;

  localparam logic [GPIO_ADDR_WIDTH-1:0] GPIO_IN         = 5'h00;
  localparam logic [GPIO_ADDR_WIDTH-1:0] GPIO_OUT        = 5'h01;
  localparam logic [GPIO_ADDR_WIDTH-1:0] GPIO_SET        = 5'h02;
  localparam logic [GPIO_ADDR_WIDTH-1:0] GPIO_CLR        = 5'h03;
  localparam logic [GPIO_ADDR_WIDTH-1:0] GPIO_TGL        = 5'h04;
  localparam logic [GPIO_ADDR_WIDTH-1:0] GPIO_RISE_EN    = 5'h05;
  localparam logic [GPIO_ADDR_WIDTH-1:0] GPIO_FALL_EN    = 5'h06;
  localparam logic [GPIO_ADDR_WIDTH-1:0] GPIO_IRQ_STATUS = 5'h07;

endpackage

// File: rtl/gpio_if.sv
// gpio_if: CPU-side bus between the memory controller I/O window and the GPIO block.
//   chip_select - window decode
//   we          - 1 = write, 0 = read
//   address     - word offset within the window
//   data_in     - write data
//   data_out    - registered read data (driven by the GPIO block)
interface gpio_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  chip_select;
  logic                  we;
  logic [4:0]            address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output chip_select,
    output we,
    output address,
    output data_in,
    input  data_out
  );

  modport slave (
    input  chip_select,
    input  we,
    input  address,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-bit, STAGES-deep flop synchroniser for asynchronous inputs.
// Clocked on the falling edge to match the rest of the GPIO block.
//   clk_i  - clock (state updates on its falling edge)
//   rst_ni - asynchronous active-low reset, clears the whole chain
//   d_i    - asynchronous inputs
//   q_o    - synchronised outputs (last stage)
module gpio_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_controller.sv
// gpio_controller: memory-mapped GPIO with synchronised inputs, an output register with
// atomic set/clear/toggle, per-bit edge detection into sticky W1C status, and a level irq.
// All state changes on the falling edge of clock so read data is stable by the next rising edge.
//   clock   - system clock
//   reset_n - asynchronous active-low reset
//   bus     - CPU bus (gpio_if slave)
//   io_in   - asynchronous external inputs
//   io_out  - output register
//   irq     - OR of all status bits
module gpio_controller
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  gpio_if.slave              bus,
  input  logic [NUM_IN-1:0]  io_in,
  output logic [NUM_OUT-1:0] io_out,
  output logic               irq
);

  logic [NUM_IN-1:0]     sync_in;
  logic [NUM_IN-1:0]     prev_d, prev_q;
  logic [NUM_OUT-1:0]    out_d, out_q;
  logic [NUM_IN-1:0]     rise_en_d, rise_en_q;
  logic [NUM_IN-1:0]     fall_en_d, fall_en_q;
  logic [NUM_IN-1:0]     status_d, status_q;
  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
  logic [NUM_IN-1:0]     rise, fall, clr_mask;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr, rd;
  logic                  unused_data;

  gpio_sync #(
    .WIDTH  (NUM_IN),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (io_in),
    .q_o    (sync_in)
  );

  assign wr = bus.chip_select && bus.we;
  assign rd = bus.chip_select && !bus.we;

  // Write bits above NUM_IN/NUM_OUT are intentionally dropped.
  assign unused_data = ^bus.data_in;

  assign rise   = sync_in & ~prev_q & rise_en_q;
  assign fall   = ~sync_in & prev_q & fall_en_q;
  assign prev_d = sync_in;

  always_comb begin
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_mask  = '0;
    if (wr) begin
      case (bus.address)
        GPIO_OUT:        out_d     = bus.data_in[NUM_OUT-1:0];
        GPIO_SET:        out_d     = out_q | bus.data_in[NUM_OUT-1:0];
        GPIO_CLR:        out_d     = out_q & ~bus.data_in[NUM_OUT-1:0];
        GPIO_TGL:        out_d     = out_q ^ bus.data_in[NUM_OUT-1:0];
        GPIO_RISE_EN:    rise_en_d = bus.data_in[NUM_IN-1:0];
        GPIO_FALL_EN:    fall_en_d = bus.data_in[NUM_IN-1:0];
        GPIO_IRQ_STATUS: clr_mask  = bus.data_in[NUM_IN-1:0];
        default:         ;
      endcase
    end
    // New edges are OR-ed in after the clear so a same-edge set wins.
    status_d = (status_q & ~clr_mask) | rise | fall;
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      GPIO_IN:         rdata[NUM_IN-1:0]  = sync_in;
      GPIO_OUT:        rdata[NUM_OUT-1:0] = out_q;
      GPIO_RISE_EN:    rdata[NUM_IN-1:0]  = rise_en_q;
      GPIO_FALL_EN:    rdata[NUM_IN-1:0]  = fall_en_q;
      GPIO_IRQ_STATUS: rdata[NUM_IN-1:0]  = status_q;
      default:         ;
    endcase
    data_out_d = rd ? rdata : '0;
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      out_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      data_out_q <= '0;
    end else begin
      prev_q     <= prev_d;
      out_q      <= out_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      data_out_q <= data_out_d;
    end
  end

  assign io_out       = out_q;
  assign irq          = |status_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_gpio_controller.sv
// tb_gpio_controller: directed self-checking bench for gpio_controller (4 in, 4 out, 2 sync stages).
module tb_gpio_controller;
  import gpio_pkg::*;

  logic       clock;
  logic       reset_n;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic       irq;
  int         n_cmp;
  int         n_fail;
  logic [31:0] rd_val;

  gpio_if #(.DATA_WIDTH(32)) bus ();

  gpio_controller #(
    .NUM_IN      (4),
    .NUM_OUT     (4),
    .DATA_WIDTH  (32),
    .SYNC_STAGES (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .io_in   (io_in),
    .io_out  (io_out),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at the rising edge, sampled by the DUT at the following falling edge.
  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(posedge clock);
    bus.chip_select = 1'b1;
    bus.we          = 1'b1;
    bus.address     = addr;
    bus.data_in     = data;
    @(negedge clock);
    #1;
    bus.chip_select = 1'b0;
    bus.we          = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    @(posedge clock);
    bus.chip_select = 1'b1;
    bus.we          = 1'b0;
    bus.address     = addr;
    bus.data_in     = '0;
    @(negedge clock);
    #1;
    data            = bus.data_out;
    bus.chip_select = 1'b0;
  endtask

  initial begin
    n_cmp           = 0;
    n_fail          = 0;
    bus.chip_select = 1'b0;
    bus.we          = 1'b0;
    bus.address     = '0;
    bus.data_in     = '0;
    io_in           = 4'hF;
    reset_n         = 1'b0;

    // Reset state
    #13;
    check("rst_io_out", {28'd0, io_out}, 32'h0);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    bus_read(GPIO_IN, rd_val);
    check("in_after_sync", rd_val, 32'h0000_000F);
    bus_read(GPIO_IRQ_STATUS, rd_val);
    check("status_after_rst", rd_val, 32'h0);

    // Output register and atomic ops
    bus_write(GPIO_OUT, 32'h5);
    check("out_write", {28'd0, io_out}, 32'h5);
    bus_write(GPIO_SET, 32'h2);
    check("out_set", {28'd0, io_out}, 32'h7);
    bus_write(GPIO_CLR, 32'h1);
    check("out_clr", {28'd0, io_out}, 32'h6);
    bus_write(GPIO_TGL, 32'hC);
    check("out_tgl", {28'd0, io_out}, 32'hA);
    bus_read(GPIO_OUT, rd_val);
    check("out_read", rd_val, 32'hA);

    // Rising edge on bit0: status sets SYNC_STAGES+1 falling edges after the change
    bus_write(GPIO_RISE_EN, 32'h1);
    bus_read(GPIO_RISE_EN, rd_val);
    check("rise_en_read", rd_val, 32'h1);
    io_in = 4'hE;
    repeat (4) @(negedge clock);
    check("no_fall_without_en", {31'd0, irq}, 32'h0);
    #1 io_in = 4'hF;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rise_irq_edge2", {31'd0, irq}, 32'h0);
    @(negedge clock);
    #1;
    check("rise_irq_edge3", {31'd0, irq}, 32'h1);
    bus_read(GPIO_IRQ_STATUS, rd_val);
    check("rise_status", rd_val, 32'h1);
    bus_read(GPIO_IRQ_STATUS, rd_val);
    check("status_read_no_clear", rd_val, 32'h1);
    bus_write(GPIO_IRQ_STATUS, 32'h1);
    check("w1c_irq", {31'd0, irq}, 32'h0);

    // Falling edge on bit1 coinciding with a W1C of bit1: set wins
    bus_write(GPIO_FALL_EN, 32'h2);
    @(negedge clock);
    #1 io_in = 4'hD;
    @(negedge clock);
    @(negedge clock);
    bus_write(GPIO_IRQ_STATUS, 32'h2);
    check("set_wins_irq", {31'd0, irq}, 32'h1);
    bus_read(GPIO_IRQ_STATUS, rd_val);
    check("set_wins_status", rd_val, 32'h2);
    bus_write(GPIO_IRQ_STATUS, 32'h2);
    bus_read(GPIO_IRQ_STATUS, rd_val);
    check("w1c_bit1", rd_val, 32'h0);

    // Write-only and unmapped offsets
    bus_read(GPIO_CLR, rd_val);
    check("read_clr_zero", rd_val, 32'h0);
    bus_read(5'h1A, rd_val);
    check("read_1a_zero", rd_val, 32'h0);
    bus_write(5'h10, 32'hFFFF_FFFF);
    check("unmapped_io_out", {28'd0, io_out}, 32'hA);
    bus_read(GPIO_RISE_EN, rd_val);
    check("unmapped_rise_en", rd_val, 32'h1);
    bus_read(GPIO_FALL_EN, rd_val);
    check("unmapped_fall_en", rd_val, 32'h2);
    bus_read(GPIO_IRQ_STATUS, rd_val);
    check("unmapped_status", rd_val, 32'h0);

    // Deselect clears data_out
    bus_read(GPIO_OUT, rd_val);
    check("read_before_desel", rd_val, 32'hA);
    @(negedge clock);
    #1;
    check("deselect_data_out", bus.data_out, 32'h0);

    // Build status 0x3 (rise on bit0, fall on bit1), then reset asynchronously
    io_in = 4'hE;
    repeat (4) @(negedge clock);
    #1 io_in = 4'hD;
    repeat (4) @(negedge clock);
    bus_read(GPIO_IRQ_STATUS, rd_val);
    check("status_both", rd_val, 32'h3);
    check("irq_both", {31'd0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_io_out", {28'd0, io_out}, 32'h0);
    check("async_rst_data_out", bus.data_out, 32'h0);
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    #3 reset_n = 1'b1;
    bus_read(GPIO_IRQ_STATUS, rd_val);
    check("post_rst_status", rd_val, 32'h0);
    bus_read(GPIO_OUT, rd_val);
    check("post_rst_out", rd_val, 32'h0);
    bus_read(GPIO_RISE_EN, rd_val);
    check("post_rst_rise_en", rd_val, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
